// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    FULL    = 2'd2,
    PRESENT = 2'd3
  } state_e;

  localparam int BYTE_W          = 8;
  localparam int FRAME_BYTES_DEF = 4;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall event detection.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the pin through the chain; remember the last synced value for edges.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: synchronises raw SPI pins, assembles LSB-first bytes
// into a frame word and hands it out over a valid/ready handshake.
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          load,
  input  logic                          sdi,
  output logic [BYTE_W-1:0]             byte_out,
  output logic                          byte_strobe,
  output logic [FRAME_BYTES*BYTE_W-1:0] frame_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic                          err_short,
  output logic                          err_overrun
);

  localparam int IDX_W = $clog2(FRAME_BYTES + 1);

  logic sck_rise, sck_fall_unused, sck_s_unused;
  logic load_rise, load_fall, load_s_unused;
  logic sdi_s, sdi_rise_unused, sdi_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .d(sck),
    .q(sck_s_unused), .rise(sck_rise), .fall(sck_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .reset(reset), .d(load),
    .q(load_s_unused), .rise(load_rise), .fall(load_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .reset(reset), .d(sdi),
    .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  state_e                          state_q, state_d;
  logic [BYTE_W-1:0]               sr_q, sr_d;
  logic [2:0]                      bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]                byte_idx_q, byte_idx_d;
  logic [BYTE_W-1:0]               byte_out_q, byte_out_d;
  logic                            byte_strobe_q, byte_strobe_d;
  logic [FRAME_BYTES*BYTE_W-1:0]   frame_q, frame_d;
  logic                            frame_valid_q, frame_valid_d;
  logic                            err_short_q, err_short_d;
  logic                            err_overrun_q, err_overrun_d;

  // Next-state and datapath: the shift happens before the completeness check,
  // so a last bit landing together with load_fall still completes the frame.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    byte_idx_d    = byte_idx_q;
    byte_out_d    = byte_out_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    byte_strobe_d = 1'b0;
    err_short_d   = 1'b0;
    err_overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_rise) begin
          sr_d       = '0;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          state_d    = RECV;
        end
      end

      RECV: begin
        if (sck_rise) begin
          sr_d      = {sdi_s, sr_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_out_d    = sr_d;
            byte_strobe_d = 1'b1;
            for (int i = 0; i < FRAME_BYTES; i++) begin
              if (byte_idx_q == IDX_W'(i)) frame_d[i*BYTE_W +: BYTE_W] = sr_d;
            end
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
        if (load_fall) begin
          if (bit_cnt_d == 3'd0 && byte_idx_d == IDX_W'(FRAME_BYTES)) begin
            state_d       = PRESENT;
            frame_valid_d = 1'b1;
          end else begin
            err_short_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (byte_idx_d == IDX_W'(FRAME_BYTES)) begin
          state_d = FULL;
        end
      end

      FULL: begin
        if (sck_rise) err_overrun_d = 1'b1;
        if (load_fall) begin
          state_d       = PRESENT;
          frame_valid_d = 1'b1;
        end
      end

      PRESENT: begin
        if (load_rise) err_overrun_d = 1'b1;
        if (frame_valid_q && frame_ready) begin
          frame_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      byte_idx_q    <= '0;
      byte_out_q    <= '0;
      byte_strobe_q <= 1'b0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_idx_q    <= byte_idx_d;
      byte_out_q    <= byte_out_d;
      byte_strobe_q <= byte_strobe_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      err_short_q   <= err_short_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_strobe = byte_strobe_q;
  assign frame_data  = frame_q;
  assign frame_valid = frame_valid_q;
  assign err_short   = err_short_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomised self-checking bench for spi_frame_rx with a transaction-level model.
module tb_spi_frame_rx;

  logic        clk = 1'b0;
  logic        reset, sck, load, sdi;
  logic        frame_ready, ready1;

  logic [7:0]  byte_out;
  logic        byte_strobe, frame_valid, err_short, err_overrun;
  logic [31:0] frame_data;

  logic [7:0]  b1_byte_out, b1_frame;
  logic        b1_strobe, b1_valid, b1_short, b1_ovr;

  spi_frame_rx #(.FRAME_BYTES(4), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .sck(sck), .load(load), .sdi(sdi),
    .byte_out(byte_out), .byte_strobe(byte_strobe), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .err_short(err_short), .err_overrun(err_overrun)
  );

  spi_frame_rx #(.FRAME_BYTES(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .sck(sck), .load(load), .sdi(sdi),
    .byte_out(b1_byte_out), .byte_strobe(b1_strobe), .frame_data(b1_frame),
    .frame_valid(b1_valid), .frame_ready(ready1),
    .err_short(b1_short), .err_overrun(b1_ovr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] obs_bytes[$];
  logic [7:0] b1_bytes[$];
  int         n_short = 0, n_ovr = 0, b1_n_short = 0, b1_n_ovr = 0;

  bit          tx_bits[$];
  logic [31:0] exp_frame;

  // Event monitor: collects strobed bytes and error pulses from both instances.
  always @(negedge clk) begin
    if (byte_strobe) obs_bytes.push_back(byte_out);
    if (err_short)   n_short++;
    if (err_overrun) n_ovr++;
    if (b1_strobe)   b1_bytes.push_back(b1_byte_out);
    if (b1_short)    b1_n_short++;
    if (b1_ovr)      b1_n_ovr++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    obs_bytes.delete();
    b1_bytes.delete();
    n_short = 0; n_ovr = 0; b1_n_short = 0; b1_n_ovr = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) tx_bits.push_back(b[j]);
  endtask

  task automatic sck_cycle(input bit b);
    sdi = b;
    repeat (3) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic drive_txn();
    clear_mon();
    load = 1'b1;
    repeat (4) @(negedge clk);
    foreach (tx_bits[i]) sck_cycle(tx_bits[i]);
    repeat (4) @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Model: bytes complete every 8 bits up to four; fewer than 32 bits is a
  // short frame, every bit beyond 32 is one overrun.
  task automatic run_and_check(input string tag);
    int n, nb;
    logic [7:0] v;
    drive_txn();
    n  = tx_bits.size();
    nb = (n / 8 > 4) ? 4 : n / 8;
    check({tag, "_nstrobe"}, 64'(obs_bytes.size()), 64'(nb));
    for (int k = 0; k < nb; k++) begin
      v = '0;
      for (int j = 0; j < 8; j++) v[j] = tx_bits[8*k+j];
      exp_frame[8*k +: 8] = v;
      if (k < obs_bytes.size()) check({tag, "_byte"}, 64'(obs_bytes[k]), 64'(v));
    end
    if (n < 32) begin
      check({tag, "_short"}, 64'(n_short), 64'd1);
      check({tag, "_ovr"},   64'(n_ovr),   64'd0);
      check({tag, "_valid"}, 64'(frame_valid), 64'd0);
    end else begin
      check({tag, "_short"}, 64'(n_short), 64'd0);
      check({tag, "_ovr"},   64'(n_ovr),   64'(n - 32));
      check({tag, "_valid"}, 64'(frame_valid), 64'd1);
      check({tag, "_frame"}, 64'(frame_data), 64'(exp_frame));
    end
  endtask

  task automatic handshake(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(frame_valid), 64'd1);
      check({tag, "_hold_frame"}, 64'(frame_data), 64'(exp_frame));
    end
    frame_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drop_valid"}, 64'(frame_valid), 64'd0);
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_out"}, 64'(byte_out), 64'd0);
    check({tag, "_strobe"},   64'(byte_strobe), 64'd0);
    check({tag, "_frame"},    64'(frame_data), 64'd0);
    check({tag, "_valid"},    64'(frame_valid), 64'd0);
    check({tag, "_eshort"},   64'(err_short), 64'd0);
    check({tag, "_eovr"},     64'(err_overrun), 64'd0);
  endtask

  initial begin
    reset = 1'b0; sck = 1'b0; load = 1'b0; sdi = 1'b0;
    frame_ready = 1'b0; ready1 = 1'b0;
    exp_frame = '0;
    repeat (5) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte A5: a complete frame for the 1-byte instance, short for the 4-byte one.
    tx_bits.delete(); push_byte(8'hA5);
    run_and_check("single4");
    check("single1_nstrobe", 64'(b1_bytes.size()), 64'd1);
    if (b1_bytes.size() > 0) check("single1_byte", 64'(b1_bytes[0]), 64'hA5);
    check("single1_valid", 64'(b1_valid), 64'd1);
    check("single1_frame", 64'(b1_frame), 64'hA5);
    check("single1_short", 64'(b1_n_short), 64'd0);
    check("single1_ovr",   64'(b1_n_ovr), 64'd0);
    ready1 = 1'b1;
    @(negedge clk);
    check("single1_drop_valid", 64'(b1_valid), 64'd0);

    // Full frame with 50 cycles of back-pressure.
    tx_bits.delete();
    push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
    run_and_check("full");
    handshake("full", 50);

    // Short frame followed by a clean frame.
    tx_bits.delete();
    push_byte(8'h9C); push_byte(8'h3E);
    tx_bits.push_back(1'b1); tx_bits.push_back(1'b0); tx_bits.push_back(1'b1);
    run_and_check("short");
    tx_bits.delete();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    run_and_check("after_short");
    handshake("after_short", 2);

    // Two extra sck edges in FULL, then a transaction while PRESENT.
    tx_bits.delete();
    push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
    tx_bits.push_back(1'b1); tx_bits.push_back(1'b0);
    run_and_check("overrun");
    tx_bits.delete(); push_byte(8'hFF);
    drive_txn();
    check("present_nstrobe", 64'(obs_bytes.size()), 64'd0);
    check("present_short",   64'(n_short), 64'd0);
    check("present_ovr",     64'(n_ovr), 64'd1);
    check("present_valid",   64'(frame_valid), 64'd1);
    check("present_frame",   64'(frame_data), 64'h78563412);
    handshake("present", 3);

    // Reset after 13 bits discards everything.
    load = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 13; i++) sck_cycle(1'($urandom_range(0, 1)));
    reset = 1'b0; load = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b1;
    repeat (6) @(negedge clk);
    tx_bits.delete();
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
    run_and_check("post_rst");
    handshake("post_rst", 1);

    // Random mix of short, exact and overrun transactions.
    for (int t = 0; t < 8; t++) begin
      int kind, n;
      kind = $urandom_range(0, 2);
      n = (kind == 0) ? $urandom_range(1, 31) : (kind == 1) ? 32 : 32 + $urandom_range(1, 3);
      tx_bits.delete();
      for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
      run_and_check("rand");
      if (n >= 32) handshake("rand", $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Downstream consumer of the SPI serial-in byte shifter stage. Takes the raw SPI pins (sck, load, sdi) into the system clock domain and assembles bytes LSB-first, using the same right-shift order as the shifter.
- Packs FRAME_BYTES bytes into one frame word and presents it to the command/decoder logic with a valid/ready handshake.
- Flags short frames and overruns.

Parameters:
- FRAME_BYTES, 4: bytes per frame; legal range 1..16.
- SYNC_STAGES, 2: synchroniser depth on sck, load and sdi; minimum 2.

Ports:
- clk  input  1  system clock; must run at least 4x the sck frequency.
- reset  input  1  synchronous, active-low reset.
- sck  input  1  SPI clock, asynchronous; data sampled on the rising edge.
- load  input  1  SPI select, asynchronous; high = transaction active.
- sdi  input  1  SPI serial data, asynchronous.
- byte_out  output  8  last completed byte.
- byte_strobe  output  1  one-cycle pulse when byte_out updates.
- frame_data  output  FRAME_BYTES*8  assembled frame; byte 0 in bits [7:0].
- frame_valid  output  1  frame_data holds a complete frame.
- frame_ready  input  1  consumer accepts the frame.
- err_short  output  1  one-cycle pulse: load fell before the frame was complete.
- err_overrun  output  1  one-cycle pulse: an sck edge or a new transaction was dropped.

Behaviour:
- Reset (reset=0 at a clk edge):
  - All outputs 0, state IDLE.
  - Synchroniser flops, shift register, bit_cnt and byte_idx all 0.
  - Reset mid-transaction discards all partial data.
- Synchronisers: SYNC_STAGES flops per input. sck_rise = synced sck high and previous synced sck low. load_rise and load_fall are detected the same way.
- Latency: a pin edge is visible as a rise/fall event SYNC_STAGES+1 clk cycles later.
- Shift rule on sck_rise in RECV:
  - sr <= {sdi_s, sr[7:1]}; bit_cnt increments and wraps 7 -> 0.
  - When bit_cnt==7: the new sr value goes to byte_out and to frame slot byte_idx. byte_strobe pulses on the following cycle, together with the updated byte_out. byte_idx increments.
- State IDLE:
  - load_rise: clear sr, bit_cnt and byte_idx, then go to RECV.
  - sck edges are ignored.
- State RECV:
  - Shift as above.
  - When byte_idx reaches FRAME_BYTES, go to FULL.
  - load_fall before the frame is complete (any bit_cnt != 0 or byte_idx < FRAME_BYTES): pulse err_short, leave frame_data unchanged, go to IDLE.
- State FULL:
  - Further sck_rise events are dropped; each pulses err_overrun.
  - load_fall: go to PRESENT and set frame_valid=1.
- State PRESENT:
  - frame_valid and frame_data are held stable until frame_valid && frame_ready is sampled.
  - On that handshake, frame_valid drops the next cycle and the state returns to IDLE.
  - A load_rise while in PRESENT pulses err_overrun; that transaction is ignored entirely. The block returns to IDLE only via the handshake and does not re-arm until the next load_rise.
- Simultaneous events:
  - load_fall and sck_rise in the same cycle in RECV: the shift is applied first, then the completeness check. A frame whose last bit lands in that cycle is valid and goes straight to PRESENT.
  - frame_ready asserted while frame_valid=0 has no effect.
- frame_data changes only on byte completion in RECV. The slot write is the only write path.

Decomposition:
- Shared package spi_rx_pkg:
  - state enum {IDLE, RECV, FULL, PRESENT}.
  - localparam BYTE_W=8 and the default FRAME_BYTES.
- Sub-module sync_edge: parameterised SYNC_STAGES synchroniser with rise/fall outputs. Instantiated three times (sck, load, sdi; edge outputs unused for sdi).

Test Plan:
- Single byte, FRAME_BYTES=1: drive load=1, shift bits 1,0,1,0,0,1,0,1 (LSB first), then load=0.
  - byte_strobe pulses once with byte_out=8'hA5.
  - frame_data=8'hA5; frame_valid=1 until frame_ready, cleared the cycle after the handshake.
- Full frame, FRAME_BYTES=4: send bytes 12,34,56,78 hex.
  - Four byte_strobe pulses.
  - frame_data=32'h78563412 after load falls.
- Short frame: 2 bytes plus 3 bits, then load=0.
  - err_short pulses once, frame_valid stays 0.
  - A following full frame 01,02,03,04 yields 32'h04030201.
- Overrun:
  - 4 bytes then 2 extra sck edges before load falls: two err_overrun pulses, frame_data=32'h78563412.
  - New load_rise while PRESENT with frame_ready=0: err_overrun pulse, frame unchanged.
- Reset mid-frame: reset=0 for one cycle after 13 bits.
  - All outputs 0.
  - The next clean frame AA,BB,CC,DD gives 32'hDDCCBBAA with no error pulses.
- Handshake back-pressure: hold frame_ready=0 for 50 cycles.
  - frame_valid and frame_data stay stable.
  - Assert frame_ready: frame_valid drops the next cycle and the state returns to IDLE.
